// File: rtl/de_morgan_pkg.sv
// Shared types and constants for the NOR gate self-test sequencer.
package de_morgan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      WAIT,
      CHECK,
      FINISH
   } state_t;

   // Combination index, bit 1 drives gate input a, bit 0 drives gate input b.
   typedef logic [1:0] comb_idx_t;

   localparam int unsigned NUM_COMB = 4;

   // Expected NOR output per combination, indexed by {a,b}.
   localparam logic [NUM_COMB-1:0] EXP_NOR = 4'b0001;

endpackage

// File: rtl/de_morgan_idx_cnt.sv
// Combination index and sweep-pass counter for the NOR self-test.
module de_morgan_idx_cnt
   import de_morgan_pkg::*;
#(
   parameter int unsigned PASSES = 1
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      clr,
   input  logic      step,
   output comb_idx_t cur_idx,
   output logic      last_comb_c,
   output logic      last_pass_c,
   output comb_idx_t idx_nxt_c
);

   localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;

   logic [PW-1:0] pass_cnt;
   logic [PW-1:0] pass_nxt;

   assign last_comb_c = (cur_idx == comb_idx_t'(NUM_COMB - 1));
   assign last_pass_c = (pass_cnt == PW'(PASSES - 1));

   // Advance index; wrap to 0 and bump the pass counter after the last combination.
   always_comb begin
      idx_nxt_c = cur_idx;
      pass_nxt  = pass_cnt;
      if (clr) begin
         idx_nxt_c = '0;
         pass_nxt  = '0;
      end else if (step) begin
         if (!last_comb_c) begin
            idx_nxt_c = cur_idx + comb_idx_t'(1);
         end else if (!last_pass_c) begin
            idx_nxt_c = '0;
            pass_nxt  = pass_cnt + PW'(1);
         end
      end
   end

   // Index and pass counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_idx  <= '0;
         pass_cnt <= '0;
      end else begin
         cur_idx  <= idx_nxt_c;
         pass_cnt <= pass_nxt;
      end
   end

endmodule

// File: rtl/de_morgan_sweep_ctrl.sv
// Sweeps all input combinations of a 2-input NOR gate, checks the output
// against ~a & ~b and reports mismatch statistics.
module de_morgan_sweep_ctrl
   import de_morgan_pkg::*;
#(
   parameter int unsigned PASSES = 1,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             dut_a,
   output logic             dut_b,
   input  logic             dut_c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       err_vec,
   output comb_idx_t        cur_idx
);

   localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [SW-1:0]    settle_cnt;
   logic [SW-1:0]    settle_nxt;
   logic [CNT_W-1:0] err_cnt_nxt;
   logic [3:0]       err_vec_nxt;
   logic             pass_nxt;
   logic             dut_a_nxt;
   logic             dut_b_nxt;
   logic             clr_c;
   logic             step_c;
   logic             last_comb_c;
   logic             last_pass_c;
   comb_idx_t        idx_nxt_c;

   de_morgan_idx_cnt #(
      .PASSES (PASSES)
   ) u_idx_cnt (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr_c),
      .step        (step_c),
      .cur_idx     (cur_idx),
      .last_comb_c (last_comb_c),
      .last_pass_c (last_pass_c),
      .idx_nxt_c   (idx_nxt_c)
   );

   // Next-state and next-output logic; abort in an active state returns to IDLE.
   always_comb begin
      state_nxt   = state;
      settle_nxt  = settle_cnt;
      err_cnt_nxt = err_cnt;
      err_vec_nxt = err_vec;
      pass_nxt    = pass;
      clr_c       = 1'b0;
      step_c      = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = APPLY;
               clr_c       = 1'b1;
               err_cnt_nxt = '0;
               err_vec_nxt = '0;
               pass_nxt    = 1'b0;
            end
         end
         APPLY: begin
            if (abort) begin
               state_nxt = IDLE;
               pass_nxt  = 1'b0;
            end else begin
               settle_nxt = SW'(SETTLE);
               state_nxt  = (SETTLE > 0) ? WAIT : CHECK;
            end
         end
         WAIT: begin
            if (abort) begin
               state_nxt = IDLE;
               pass_nxt  = 1'b0;
            end else if (settle_cnt <= SW'(1)) begin
               state_nxt = CHECK;
            end else begin
               settle_nxt = settle_cnt - SW'(1);
            end
         end
         CHECK: begin
            if (abort) begin
               state_nxt = IDLE;
               pass_nxt  = 1'b0;
            end else begin
               if (dut_c != EXP_NOR[cur_idx]) begin
                  err_vec_nxt[cur_idx] = 1'b1;
                  if (err_cnt != {CNT_W{1'b1}}) begin
                     err_cnt_nxt = err_cnt + CNT_W'(1);
                  end
               end
               step_c    = 1'b1;
               state_nxt = (last_comb_c && last_pass_c) ? FINISH : APPLY;
            end
         end
         FINISH: begin
            pass_nxt  = (err_cnt == '0);
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Gate inputs follow the index while a combination is applied, else idle low.
      if (state_nxt == APPLY || state_nxt == WAIT || state_nxt == CHECK) begin
         dut_a_nxt = idx_nxt_c[1];
         dut_b_nxt = idx_nxt_c[0];
      end else begin
         dut_a_nxt = 1'b0;
         dut_b_nxt = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         err_cnt    <= '0;
         err_vec    <= '0;
         pass       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dut_a      <= 1'b0;
         dut_b      <= 1'b0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         err_cnt    <= err_cnt_nxt;
         err_vec    <= err_vec_nxt;
         pass       <= pass_nxt;
         busy       <= (state_nxt != IDLE);
         done       <= (state_nxt == FINISH);
         dut_a      <= dut_a_nxt;
         dut_b      <= dut_b_nxt;
      end
   end

endmodule

// File: tb/tb_de_morgan_sweep_ctrl.sv
// Directed bench for de_morgan_sweep_ctrl with three parameterisations.
module tb_de_morgan_sweep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic rst;
   logic start0, start1, start2;
   logic abort0, abort1, abort2;
   logic [1:0] mode0, mode1, mode2;

   logic       a0, b0, c0, busy0, done0, pass0;
   logic [7:0] err0;
   logic [3:0] vec0;
   logic [1:0] idx0;

   logic       a1, b1, c1, busy1, done1, pass1;
   logic [7:0] err1;
   logic [3:0] vec1;
   logic [1:0] idx1;

   logic       a2, b2, c2, busy2, done2, pass2;
   logic [1:0] err2;
   logic [3:0] vec2;
   logic [1:0] idx2;

   // Gate models: 0 correct NOR, 1 stuck-at-0, 2 stuck-at-1, 3 OR gate.
   function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
      case (m)
         2'd0:    return ~(a | b);
         2'd1:    return 1'b0;
         2'd2:    return 1'b1;
         default: return a | b;
      endcase
   endfunction

   assign c0 = gate(mode0, a0, b0);
   assign c1 = gate(mode1, a1, b1);
   assign c2 = gate(mode2, a2, b2);

   de_morgan_sweep_ctrl u0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0),
      .dut_a(a0), .dut_b(b0), .dut_c(c0), .busy(busy0), .done(done0),
      .pass(pass0), .err_cnt(err0), .err_vec(vec0), .cur_idx(idx0)
   );

   de_morgan_sweep_ctrl #(.PASSES(3), .SETTLE(1), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .dut_a(a1), .dut_b(b1), .dut_c(c1), .busy(busy1), .done(done1),
      .pass(pass1), .err_cnt(err1), .err_vec(vec1), .cur_idx(idx1)
   );

   de_morgan_sweep_ctrl #(.PASSES(2), .SETTLE(0), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .dut_a(a2), .dut_b(b2), .dut_c(c2), .busy(busy2), .done(done2),
      .pass(pass2), .err_cnt(err2), .err_vec(vec2), .cur_idx(idx2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Start u0, wait for done within a bound, check latency, step past FINISH.
   task automatic run_u0(input string tag);
      int cyc;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      cyc = 1;
      while (!done0 && cyc < 40) begin
         tick();
         cyc++;
      end
      chk(tag, 32'(cyc), 32'd13);
      tick();
   endtask

   initial begin
      int d1, d2, p1, p2;
      rst = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      abort0 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
      mode0 = 2'd0; mode1 = 2'd2; mode2 = 2'd2;
      tick();
      tick();

      chk("rst_busy",  32'(busy0), 32'd0);
      chk("rst_done",  32'(done0), 32'd0);
      chk("rst_pass",  32'(pass0), 32'd0);
      chk("rst_err",   32'(err0),  32'd0);
      chk("rst_vec",   32'(vec0),  32'd0);
      chk("rst_idx",   32'(idx0),  32'd0);
      chk("rst_ab",    32'({a0, b0}), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_err2",  32'(err2),  32'd0);
      rst = 1'b0;
      tick();

      // Correct gate, cycle-by-cycle sweep with done in cycle 13.
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         chk($sformatf("nor_done_c%0d", k), 32'(done0), 32'(k == 13));
         if (k <= 12) begin
            chk($sformatf("nor_ab_c%0d", k), 32'({a0, b0}), 32'((k - 1) / 3));
         end
         if (k % 3 == 1 && k < 13) begin
            chk($sformatf("nor_idx_c%0d", k), 32'(idx0), 32'((k - 1) / 3));
         end
         if (k < 13) tick();
      end
      tick();
      chk("nor_pass", 32'(pass0), 32'd1);
      chk("nor_err",  32'(err0),  32'd0);
      chk("nor_vec",  32'(vec0),  32'd0);
      chk("nor_busy", 32'(busy0), 32'd0);

      // Stuck-at-0 output: only combination 00 fails.
      mode0 = 2'd1;
      run_u0("sa0_lat");
      chk("sa0_vec",  32'(vec0),  32'b0001);
      chk("sa0_err",  32'(err0),  32'd1);
      chk("sa0_pass", 32'(pass0), 32'd0);

      // OR gate substituted: every combination fails.
      mode0 = 2'd3;
      run_u0("or_lat");
      chk("or_vec",  32'(vec0),  32'b1111);
      chk("or_err",  32'(err0),  32'd4);
      chk("or_pass", 32'(pass0), 32'd0);

      // start held during cycles 2..13 is ignored; done still in cycle 13.
      mode0 = 2'd0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         chk($sformatf("restart_done_c%0d", k), 32'(done0), 32'(k == 13));
         start0 = (k >= 2);
         tick();
      end
      start0 = 1'b0;
      chk("restart_busy", 32'(busy0), 32'd0);
      chk("restart_pass", 32'(pass0), 32'd1);

      // Abort in cycle 6 with stuck-at-0: IDLE in cycle 7, partial stats kept.
      mode0 = 2'd1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 1; k < 6; k++) tick();
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_done", 32'(done0), 32'd0);
      chk("abort_pass", 32'(pass0), 32'd0);
      chk("abort_vec",  32'(vec0),  32'b0001);
      chk("abort_err",  32'(err0),  32'd1);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("abort_nodone", 32'(done0), 32'd0);
      end

      // Reset asserted in cycle 5 of a run.
      mode0 = 2'd3;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 1; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", 32'(busy0), 32'd0);
      chk("midrst_done", 32'(done0), 32'd0);
      chk("midrst_err",  32'(err0),  32'd0);
      chk("midrst_vec",  32'(vec0),  32'd0);
      chk("midrst_idx",  32'(idx0),  32'd0);
      chk("midrst_ab",   32'({a0, b0}), 32'd0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("midrst_nodone", 32'(done0), 32'd0);
      end
      mode0 = 2'd0;
      run_u0("postrst_lat");
      chk("postrst_pass", 32'(pass0), 32'd1);

      // Multi-pass configurations with stuck-at-1 output.
      start1 = 1'b1;
      start2 = 1'b1;
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
      d1 = 0; d2 = 0; p1 = 0; p2 = 0;
      for (int k = 1; k <= 45; k++) begin
         if (done1) begin
            p1++;
            if (d1 == 0) d1 = k;
         end
         if (done2) begin
            p2++;
            if (d2 == 0) d2 = k;
         end
         tick();
      end
      chk("p3_lat",    32'(d1),    32'd37);
      chk("p3_pulses", 32'(p1),    32'd1);
      chk("p3_err",    32'(err1),  32'd9);
      chk("p3_vec",    32'(vec1),  32'b1110);
      chk("p3_pass",   32'(pass1), 32'd0);
      chk("p3_busy",   32'(busy1), 32'd0);
      chk("sat_lat",   32'(d2),    32'd17);
      chk("sat_pulses",32'(p2),    32'd1);
      chk("sat_err",   32'(err2),  32'd3);
      chk("sat_vec",   32'(vec2),  32'b1110);
      chk("sat_pass",  32'(pass2), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
